dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-ported 128-word data SRAM between the processor's load/store path (port 0) and a secondary requester such as a DMA or test loader (port 1). Each port has a valid/ready request channel and a fixed-latency response channel. The arbiter registers the winning command, drives the SRAM control pins for exactly one cycle, and returns read data two cycles after acceptance. It sits between the core's memory-stage outputs and the SRAM macro pins (CEN/WEN/OEN/A/Data2Mem/ReadDataMem).

## Interface
- ADDR_W, 7: word address width; drives A directly.
- DATA_W, 32: data width.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- req0_valid / req1_valid  in  1  request present on port 0 / 1.
- req0_we / req1_we  in  1  1 = write, 0 = read.
- req0_addr / req1_addr  in  ADDR_W  word address.
- req0_wdata / req1_wdata  in  DATA_W  write data.
- req0_ready / req1_ready  out  1  grant; a request is accepted on any edge where valid && ready.
- rsp0_valid / rsp1_valid  out  1  one-cycle pulse carrying read data.
- rsp0_rdata / rsp1_rdata  out  DATA_W  read data; holds its last value when rsp_valid = 0.
- CEN  out  1  SRAM chip enable, active-low.
- WEN  out  1  SRAM write enable, active-low (0 = write, 1 = read).
- OEN  out  1  SRAM output enable, active-low; 0 only during read access cycles.
- A  out  ADDR_W  SRAM address.
- Data2Mem  out  DATA_W  SRAM write data.
- ReadDataMem  in  DATA_W  SRAM read data; valid combinationally within the access cycle.

## Operation
- Arbitration is combinational from req*_valid and the priority pointer `prio` (0 or 1).
  - Only one port valid: that port gets ready = 1.
  - Both ports valid: port `prio` gets ready = 1; the other gets ready = 0.
  - Neither valid: both readies are 0.
  - At most one ready is high in any cycle.
- Readies are forced to 0 while rst_n = 0.
- Readies may depend on valid. Requesters must not make valid depend on ready, and must hold valid, we, addr and wdata stable until accepted.
- Priority pointer: after every accepted request, `prio` <= the non-granted port. No update in cycles without a grant. Reset value is 0.
- Command register: on acceptance, {we, addr, wdata, port} is captured and cmd_vld <= 1. Otherwise cmd_vld <= 0.
- Pins when cmd_vld = 1:
  - CEN = 0.
  - WEN = ~we.
  - OEN = we (i.e. 0 for reads, 1 for writes).
  - A = addr.
  - Data2Mem = wdata.
- Pins when cmd_vld = 0:
  - CEN = 1, WEN = 1, OEN = 1.
  - A and Data2Mem hold their last driven values.
- Read response: at the end of a read access cycle, ReadDataMem is registered into rsp<port>_rdata and rsp<port>_valid pulses for one cycle. Writes produce no response.
- Responses have no backpressure; requesters must always accept them.
- Requests complete in acceptance order, so read-after-write to the same address returns the new data.

## Timing
- Throughput: one accepted request per cycle, sustained, across both ports combined.
- Request accepted at edge E (end of cycle T):
  - Cycle T+1: SRAM pins driven for that command.
  - Cycle T+2: read response valid. Read latency is 2 cycles from acceptance.
- Back-to-back commands drive the pins on consecutive cycles with CEN held at 0.
- Reset values: CEN = WEN = OEN = 1; A = 0; Data2Mem = 0; rsp*_valid = 0; rsp*_rdata = 0; cmd_vld = 0; prio = 0.
- Reset mid-operation: if rst_n = 0 at an edge,
  - a captured command is discarded: no pin activity next cycle;
  - a read in its access cycle produces no rsp_valid;
  - requests presented during reset are not accepted.
- Simultaneous new requests on both ports while a command is in its access cycle: arbitration proceeds normally. The access-cycle command does not block acceptance.

## Configuration
- DMEM_ARB_FIXED_PRIO_EN defined: port 0 always wins when both ports are valid, and `prio` is not implemented. Port 1 may starve; this is intended, so the CPU never stalls behind DMA.
- Undefined (default): round-robin via `prio` as described above.

## Test plan
- Single write, then read: port 0 writes addr 0x05 data 0xDEADBEEF at cycle 1; port 0 reads 0x05 at cycle 2.
  - Cycle 2 pins: CEN = 0, WEN = 0, OEN = 1, A = 0x05, Data2Mem = 0xDEADBEEF.
  - rsp0_valid = 1 with rsp0_rdata = 0xDEADBEEF at cycle 4.
- Contention, round-robin: both ports hold reads (port 0 addr 0x01, port 1 addr 0x02) for 4 cycles after reset.
  - Grants alternate 0,1,0,1.
  - A sequence is 0x01,0x02,0x01,0x02.
- Contention with DMEM_ARB_FIXED_PRIO_EN: same stimulus.
  - req1_ready stays 0 for all 4 cycles.
  - Port 1 is granted in the first cycle port 0 drops valid.
- Idle hold: after a write to 0x7F with data 0x12345678, no requests for 3 cycles.
  - CEN = WEN = OEN = 1.
  - A stays 0x7F and Data2Mem stays 0x12345678.
- Reset mid-read: port 1 read accepted at cycle 5; rst_n = 0 at cycle 6.
  - No rsp1_valid pulse.
  - All outputs equal their reset values at cycle 7.
- Read-after-write across ports: port 1 writes 0x10 = 0xA5A5A5A5, port 0 reads 0x10 in the next cycle.
  - rsp0_rdata = 0xA5A5A5A5.

Source files
------------

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter for the 128-word data SRAM; DMEM_ARB_FIXED_PRIO_EN selects fixed port-0 priority
module dmem_arbiter #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] Data2Mem,
    input  logic [DATA_W-1:0] ReadDataMem
);

    logic              grant0;
    logic              grant1;
    logic              accept;

    logic              cmd_vld_q,   cmd_vld_d;
    logic              cmd_we_q,    cmd_we_d;
    logic              cmd_port_q,  cmd_port_d;
    logic [ADDR_W-1:0] cmd_addr_q,  cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;

    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
    logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

    assign accept = grant0 | grant1;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // Port 0 always wins; port 1 only gets the SRAM when port 0 is idle
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            grant0 = req0_valid;
            grant1 = req1_valid & ~req0_valid;
        end
    end
`else
    logic prio_q, prio_d;

    // Sole requester wins; on contention the port named by prio wins
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (rst_n) begin
            if (req0_valid && req1_valid) begin
                grant0 = ~prio_q;
                grant1 = prio_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // After each grant the pointer moves to the port that was not served
    always_comb begin
        prio_d = prio_q;
        if (accept) begin
            prio_d = grant0;
        end
    end

    // Priority pointer register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`endif

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Capture the winning command; address/data hold when nothing is accepted
    always_comb begin
        cmd_vld_d   = accept;
        cmd_we_d    = cmd_we_q;
        cmd_port_d  = cmd_port_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        if (grant0) begin
            cmd_we_d    = req0_we;
            cmd_port_d  = 1'b0;
            cmd_addr_d  = req0_addr;
            cmd_wdata_d = req0_wdata;
        end else if (grant1) begin
            cmd_we_d    = req1_we;
            cmd_port_d  = 1'b1;
            cmd_addr_d  = req1_addr;
            cmd_wdata_d = req1_wdata;
        end
    end

    // A read in its access cycle lands in the owning port's response register
    always_comb begin
        rsp0_valid_d = cmd_vld_q & ~cmd_we_q & ~cmd_port_q;
        rsp1_valid_d = cmd_vld_q & ~cmd_we_q &  cmd_port_q;
        rsp0_rdata_d = rsp0_valid_d ? ReadDataMem : rsp0_rdata_q;
        rsp1_rdata_d = rsp1_valid_d ? ReadDataMem : rsp1_rdata_q;
    end

    // Command and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_vld_q    <= 1'b0;
            cmd_we_q     <= 1'b0;
            cmd_port_q   <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
        end else begin
            cmd_vld_q    <= cmd_vld_d;
            cmd_we_q     <= cmd_we_d;
            cmd_port_q   <= cmd_port_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_rdata_q <= rsp0_rdata_d;
            rsp1_rdata_q <= rsp1_rdata_d;
        end
    end

    assign CEN        = ~cmd_vld_q;
    assign WEN        = ~(cmd_vld_q & cmd_we_q);
    assign OEN        = ~(cmd_vld_q & ~cmd_we_q);
    assign A          = cmd_addr_q;
    assign Data2Mem   = cmd_wdata_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed vector table plus randomized traffic against a transaction-level model
module tb_dmem_arbiter;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] HH = 32'h12345678;
    localparam logic [31:0] W1 = 32'h11111111;
    localparam logic [31:0] W2 = 32'h22222222;
    localparam logic [31:0] A5 = 32'hA5A5A5A5;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_we, req1_valid, req1_we;
    logic [6:0]  req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        CEN, WEN, OEN;
    logic [6:0]  A;
    logic [31:0] Data2Mem, ReadDataMem;

    logic [31:0] sram [128];

    int n_vec = 0;
    int n_err = 0;

    dmem_arbiter #(.ADDR_W(7), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .CEN(CEN), .WEN(WEN), .OEN(OEN), .A(A), .Data2Mem(Data2Mem),
        .ReadDataMem(ReadDataMem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro behaviour: synchronous write, combinational read
    always @(posedge clk) begin
        if (!CEN && !WEN) sram[A] <= Data2Mem;
    end
    assign ReadDataMem = sram[A];

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        bit          port;
        bit          we;
        logic [6:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t        txq[$];
    logic [31:0] refmem [128];
    bit          m_prio;
    int          cyc;
    logic [6:0]  last_a;
    logic [31:0] last_d;
    logic [31:0] last_rd0, last_rd1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic void exp_ready(output bit r0, output bit r1);
        r0 = 1'b0;
        r1 = 1'b0;
        if (rst_n) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            r0 = req0_valid;
            r1 = req1_valid && !req0_valid;
`else
            if (req0_valid && req1_valid) begin
                r0 = (m_prio == 1'b0);
                r1 = (m_prio == 1'b1);
            end else begin
                r0 = req0_valid;
                r1 = req1_valid;
            end
`endif
        end
    endfunction

    // Compare all outputs in the current cycle against the transaction history
    function automatic void model_check();
        bit          r0, r1;
        bit          e_rv0, e_rv1;
        logic        e_cen, e_wen, e_oen;
        logic [31:0] e_rd0, e_rd1;
        txn_t        t;
        exp_ready(r0, r1);
        while (txq.size() > 0 && txq[0].cyc < cyc - 2) begin
            t = txq.pop_front();
            if (!t.we) begin
                if (t.port) last_rd1 = t.rdata; else last_rd0 = t.rdata;
            end
        end
        e_rv0 = 1'b0; e_rv1 = 1'b0;
        e_rd0 = last_rd0; e_rd1 = last_rd1;
        if (txq.size() > 0 && txq[0].cyc == cyc - 2 && !txq[0].we) begin
            if (txq[0].port) begin e_rv1 = 1'b1; e_rd1 = txq[0].rdata; end
            else begin e_rv0 = 1'b1; e_rd0 = txq[0].rdata; end
        end
        e_cen = 1'b1; e_wen = 1'b1; e_oen = 1'b1;
        if (txq.size() > 0 && txq[txq.size()-1].cyc == cyc - 1) begin
            t = txq[txq.size()-1];
            e_cen = 1'b0;
            e_wen = !t.we;
            e_oen = t.we;
        end
        chk("m_ready0", req0_ready, r0);
        chk("m_ready1", req1_ready, r1);
        chk("m_CEN", CEN, e_cen);
        chk("m_WEN", WEN, e_wen);
        chk("m_OEN", OEN, e_oen);
        chk("m_A", A, last_a);
        chk("m_Data2Mem", Data2Mem, last_d);
        chk("m_rsp0_valid", rsp0_valid, e_rv0);
        chk("m_rsp1_valid", rsp1_valid, e_rv1);
        chk("m_rsp0_rdata", rsp0_rdata, e_rd0);
        chk("m_rsp1_rdata", rsp1_rdata, e_rd1);
    endfunction

    // Advance the model across a rising edge; reports which port was accepted
    function automatic void model_edge(output bit g0, output bit g1);
        bit   r0, r1;
        txn_t t;
        exp_ready(r0, r1);
        g0 = r0 && req0_valid;
        g1 = r1 && req1_valid;
        if (!rst_n) begin
            txq.delete();
            last_a = '0; last_d = '0; last_rd0 = '0; last_rd1 = '0;
            m_prio = 1'b0;
            g0 = 1'b0; g1 = 1'b0;
        end else if (g0 || g1) begin
            t.cyc   = cyc;
            t.port  = g1;
            t.we    = g1 ? req1_we    : req0_we;
            t.addr  = g1 ? req1_addr  : req0_addr;
            t.wdata = g1 ? req1_wdata : req0_wdata;
            t.rdata = refmem[t.addr];
            if (t.we) refmem[t.addr] = t.wdata;
            txq.push_back(t);
            last_a = t.addr;
            last_d = t.wdata;
            m_prio = !t.port;
        end
        cyc++;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          rst_n;
        bit          v0, we0; logic [6:0] a0; logic [31:0] d0;
        bit          v1, we1; logic [6:0] a1; logic [31:0] d1;
        bit          r0, r1, cen, wen, oen;
        logic [6:0]  a;  logic [31:0] d;
        bit          rv0, rv1;
        logic [31:0] rd0, rd1;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit rs, bit v0, bit we0, logic [6:0] a0, logic [31:0] d0,
                                bit v1, bit we1, logic [6:0] a1, logic [31:0] d1,
                                bit r0, bit r1, bit cen, bit wen, bit oen,
                                logic [6:0] a, logic [31:0] d, bit rv0, bit rv1,
                                logic [31:0] rd0, logic [31:0] rd1);
        vec_t v;
        v.rst_n = rs; v.v0 = v0; v.we0 = we0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.we1 = we1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1; v.cen = cen; v.wen = wen; v.oen = oen;
        v.a = a; v.d = d; v.rv0 = rv0; v.rv1 = rv1; v.rd0 = rd0; v.rd1 = rd1;
        tbl.push_back(v);
    endfunction

    function automatic void tbl_check(vec_t v, int i);
        chk($sformatf("t%0d_ready0", i), req0_ready, v.r0);
        chk($sformatf("t%0d_ready1", i), req1_ready, v.r1);
        chk($sformatf("t%0d_CEN", i), CEN, v.cen);
        chk($sformatf("t%0d_WEN", i), WEN, v.wen);
        chk($sformatf("t%0d_OEN", i), OEN, v.oen);
        chk($sformatf("t%0d_A", i), A, v.a);
        chk($sformatf("t%0d_Data2Mem", i), Data2Mem, v.d);
        chk($sformatf("t%0d_rsp0_valid", i), rsp0_valid, v.rv0);
        chk($sformatf("t%0d_rsp1_valid", i), rsp1_valid, v.rv1);
        chk($sformatf("t%0d_rsp0_rdata", i), rsp0_rdata, v.rd0);
        chk($sformatf("t%0d_rsp1_rdata", i), rsp1_rdata, v.rd1);
    endfunction

    function automatic logic [6:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 7'($urandom_range(0, 127));
        return 7'($urandom_range(0, 7));
    endfunction

    initial begin
        bit g0, g1;
        for (int i = 0; i < 128; i++) begin
            sram[i]   = '0;
            refmem[i] = '0;
        end
        m_prio = 1'b0; cyc = 0;
        last_a = '0; last_d = '0; last_rd0 = '0; last_rd1 = '0;
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0;

        //   rst v0 we0 a0     d0  v1 we1 a1     d1  r0 r1 cen wen oen a      d   rv0 rv1 rd0 rd1
        add(0, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 1, 1, 1, 7'h00, 0,  0, 0, 0,  0);
        add(1, 1, 1, 7'h05, DB, 0, 0, 7'h00, 0,  1, 0, 1, 1, 1, 7'h00, 0,  0, 0, 0,  0);
        add(1, 1, 0, 7'h05, 0,  0, 0, 7'h00, 0,  1, 0, 0, 0, 1, 7'h05, DB, 0, 0, 0,  0);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 0, 1, 0, 7'h05, 0,  0, 0, 0,  0);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 1, 1, 1, 7'h05, 0,  1, 0, DB, 0);
        add(1, 1, 1, 7'h7F, HH, 0, 0, 7'h00, 0,  1, 0, 1, 1, 1, 7'h05, 0,  0, 0, DB, 0);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 0, 0, 1, 7'h7F, HH, 0, 0, DB, 0);
        for (int k = 0; k < 3; k++)
            add(1, 0, 0, 7'h00, 0, 0, 0, 7'h00, 0, 0, 0, 1, 1, 1, 7'h7F, HH, 0, 0, DB, 0);
        add(1, 1, 1, 7'h01, W1, 0, 0, 7'h00, 0,  1, 0, 1, 1, 1, 7'h7F, HH, 0, 0, DB, 0);
        add(1, 0, 0, 7'h00, 0,  1, 1, 7'h02, W2, 0, 1, 0, 0, 1, 7'h01, W1, 0, 0, DB, 0);
        add(0, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 0, 0, 1, 7'h02, W2, 0, 0, DB, 0);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 1, 1, 1, 7'h00, 0,  0, 0, 0,  0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
        add(1, 1, 0, 7'h01, 0,  1, 0, 7'h02, 0,  1, 0, 1, 1, 1, 7'h00, 0,  0, 0, 0,  0);
        add(1, 1, 0, 7'h01, 0,  1, 0, 7'h02, 0,  1, 0, 0, 1, 0, 7'h01, 0,  0, 0, 0,  0);
        add(1, 1, 0, 7'h01, 0,  1, 0, 7'h02, 0,  1, 0, 0, 1, 0, 7'h01, 0,  1, 0, W1, 0);
        add(1, 1, 0, 7'h01, 0,  1, 0, 7'h02, 0,  1, 0, 0, 1, 0, 7'h01, 0,  1, 0, W1, 0);
        add(1, 0, 0, 7'h00, 0,  1, 0, 7'h02, 0,  0, 1, 0, 1, 0, 7'h01, 0,  1, 0, W1, 0);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 0, 1, 0, 7'h02, 0,  1, 0, W1, 0);
`else
        add(1, 1, 0, 7'h01, 0,  1, 0, 7'h02, 0,  1, 0, 1, 1, 1, 7'h00, 0,  0, 0, 0,  0);
        add(1, 1, 0, 7'h01, 0,  1, 0, 7'h02, 0,  0, 1, 0, 1, 0, 7'h01, 0,  0, 0, 0,  0);
        add(1, 1, 0, 7'h01, 0,  1, 0, 7'h02, 0,  1, 0, 0, 1, 0, 7'h02, 0,  1, 0, W1, 0);
        add(1, 1, 0, 7'h01, 0,  1, 0, 7'h02, 0,  0, 1, 0, 1, 0, 7'h01, 0,  0, 1, W1, W2);
        add(1, 0, 0, 7'h00, 0,  1, 0, 7'h02, 0,  0, 1, 0, 1, 0, 7'h02, 0,  1, 0, W1, W2);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 0, 1, 0, 7'h02, 0,  0, 1, W1, W2);
`endif
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 1, 1, 1, 7'h02, 0,  0, 1, W1, W2);
        add(1, 0, 0, 7'h00, 0,  1, 0, 7'h02, 0,  0, 1, 1, 1, 1, 7'h02, 0,  0, 0, W1, W2);
        add(0, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 0, 1, 0, 7'h02, 0,  0, 0, W1, W2);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 1, 1, 1, 7'h00, 0,  0, 0, 0,  0);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 1, 1, 1, 7'h00, 0,  0, 0, 0,  0);
        add(1, 0, 0, 7'h00, 0,  1, 1, 7'h10, A5, 0, 1, 1, 1, 1, 7'h00, 0,  0, 0, 0,  0);
        add(1, 1, 0, 7'h10, 0,  0, 0, 7'h00, 0,  1, 0, 0, 0, 1, 7'h10, A5, 0, 0, 0,  0);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 0, 1, 0, 7'h10, 0,  0, 0, 0,  0);
        add(1, 0, 0, 7'h00, 0,  0, 0, 7'h00, 0,  0, 0, 1, 1, 1, 7'h10, 0,  1, 0, A5, 0);

        repeat (2) begin
            @(posedge clk);
            model_edge(g0, g1);
        end
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            rst_n      = tbl[i].rst_n;
            req0_valid = tbl[i].v0; req0_we = tbl[i].we0;
            req0_addr  = tbl[i].a0; req0_wdata = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_we = tbl[i].we1;
            req1_addr  = tbl[i].a1; req1_wdata = tbl[i].d1;
            @(negedge clk);
            model_check();
            tbl_check(tbl[i], i);
            @(posedge clk);
            model_edge(g0, g1);
            #1;
        end

        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 1500; k++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            if (!req0_valid && $urandom_range(0, 2) != 0) begin
                req0_valid = 1'b1;
                req0_we    = 1'($urandom_range(0, 1));
                req0_addr  = rnd_addr();
                req0_wdata = $urandom();
            end
            if (!req1_valid && $urandom_range(0, 2) != 0) begin
                req1_valid = 1'b1;
                req1_we    = 1'($urandom_range(0, 1));
                req1_addr  = rnd_addr();
                req1_wdata = $urandom();
            end
            @(negedge clk);
            model_check();
            @(posedge clk);
            model_edge(g0, g1);
            #1;
            if (g0) req0_valid = 1'b0;
            if (g1) req1_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
